// File: rtl/buzzer_mixer.sv
// -----------------------------------------------------------------------------
// buzzer_mixer
//   N-channel mixer for 1-bit buzzer pins. Each pin is synchronised and its
//   level is smoothed by a first-order IIR that steps towards 0 or CH_FS. The
//   level is scaled by a per-channel volume and added into a saturating sum.
//   The channels share one datapath, one channel per clock, and one sample is
//   produced every CE_DIV clocks.
//
// Ports
//   clk_sys       system clock
//   reset         asynchronous, active-high
//   enable        0 freezes the divider, the FSM, the levels and the outputs
//   mute          1 forces the sample to silence; the levels keep updating
//   buzzer        raw buzzer pins, asynchronous to clk_sys
//   volume        channel i volume = volume[i*VOL_W +: VOL_W]
//   audio_out     current sample, held between sample_valid pulses
//   sample_valid  1-cycle pulse when audio_out updates
//   clip          1-cycle pulse with sample_valid when the sum saturated
// -----------------------------------------------------------------------------
module buzzer_mixer #(
  parameter int               CHANNELS   = 2,
  parameter int               OUT_W      = 16,
  parameter int               VOL_W      = 4,
  parameter int               SHIFT      = 4,
  parameter logic [OUT_W-1:0] CH_FS      = 16'h7FFF,
  parameter int               CE_DIV     = 1024,
  parameter bit               SIGNED_OUT = 1'b0
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mute,
  input  logic [CHANNELS-1:0]       buzzer,
  input  logic [CHANNELS*VOL_W-1:0] volume,
  output logic [OUT_W-1:0]          audio_out,
  output logic                      sample_valid,
  output logic                      clip
);

  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W  = OUT_W + $clog2(CHANNELS) + 1;
  localparam int DIV_W  = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int PROD_W = OUT_W + VOL_W + 1;

  // Silence code; XOR-ing a result with it turns unsigned into offset binary.
  localparam logic [OUT_W-1:0] SILENCE  = SIGNED_OUT ? {1'b1, {(OUT_W-1){1'b0}}} : '0;
  localparam logic [ACC_W-1:0] FULL     = ACC_W'({OUT_W{1'b1}});
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_OUT} state_e;

  state_e                      state_q, state_d;
  logic [CHANNELS-1:0]         meta_q, sync_q;
  logic [CHANNELS-1:0]         bits_q, bits_d;
  logic [CHANNELS*VOL_W-1:0]   vol_q, vol_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [ACC_W-1:0]            sum_q, sum_d;
  logic [OUT_W-1:0]            level_q [CHANNELS];
  logic [OUT_W-1:0]            audio_q, audio_d;
  logic                        valid_q, valid_d;
  logic                        clip_q, clip_d;
  logic                        level_we;

  logic                        tick;
  logic [OUT_W-1:0]            cur_level, tgt, level_new, res;
  logic signed [OUT_W:0]       diff, step;
  logic [VOL_W-1:0]            vol_ch;
  logic [PROD_W-1:0]           prod, weight;
  logic                        sat;

  assign tick         = enable && (div_q == DIV_LAST);
  assign audio_out    = audio_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;

  // Two-flop synchroniser for the asynchronous buzzer pins.
  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= buzzer;
      sync_q <= meta_q;
    end
  end

  // Shared per-channel datapath for channel idx_q.
  // NOTE: every variable assigned in a combinational block gets a value on
  // every path (defaults first), otherwise a latch is inferred.
  always_comb begin
    cur_level = level_q[idx_q];
    tgt       = bits_q[idx_q] ? CH_FS : '0;
    diff      = $signed({1'b0, tgt}) - $signed({1'b0, cur_level});
    step      = diff >>> SHIFT;
    // A residue below 2^SHIFT would shift to zero; force a unit step so the
    // level lands exactly on the target.
    if (step == '0 && diff != '0) begin
      step = diff[OUT_W] ? '1 : (OUT_W+1)'(1);
    end
    // |step| <= |diff|, so the sum stays within [0, CH_FS] and the low bits
    // of a modular add are exact.
    level_new = cur_level + step[OUT_W-1:0];
    vol_ch    = vol_q[idx_q*VOL_W +: VOL_W];
    prod      = PROD_W'(level_new) * PROD_W'({1'b0, vol_ch} + (VOL_W+1)'(1));
    weight    = (vol_ch == '0) ? '0 : (prod >> VOL_W);
  end

  // Next-state logic and output formation.
  always_comb begin
    state_d  = state_q;
    bits_d   = bits_q;
    vol_d    = vol_q;
    div_d    = div_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    audio_d  = audio_q;
    valid_d  = 1'b0;
    clip_d   = 1'b0;
    level_we = 1'b0;
    res      = '0;
    sat      = 1'b0;
    if (enable) begin
      div_d = tick ? '0 : div_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (tick) begin
            bits_d  = sync_q;
            vol_d   = volume;
            sum_d   = '0;
            idx_d   = '0;
            state_d = ST_CALC;
          end
        end
        ST_CALC: begin
          level_we = 1'b1;
          sum_d    = sum_q + ACC_W'(weight);
          if (idx_q == LAST_IDX) begin
            // The output registers load on the edge into OUT so the new
            // sample and its pulses are visible for the whole OUT cycle.
            if (sum_d > FULL) begin
              res = '1;
              sat = 1'b1;
            end else begin
              res = sum_d[OUT_W-1:0];
            end
            if (mute) begin
              res = '0;
              sat = 1'b0;
            end
            audio_d = res ^ SILENCE;
            valid_d = 1'b1;
            clip_d  = sat;
            state_d = ST_OUT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_OUT:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bits_q  <= '0;
      vol_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      audio_q <= SILENCE;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      vol_q   <= vol_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      audio_q <= audio_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
    end
  end

  // NOTE: the level array is a handful of flops whose contents are audible
  // state, so it is reset like any other register rather than left as RAM.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) level_q[i] <= '0;
    end else if (level_we) begin
      level_q[idx_q] <= level_new;
    end
  end

`ifndef SYNTHESIS
  // A tick arriving while a sample is still being computed would be lost.
  a_tick_idle : assert property (@(posedge clk_sys) disable iff (reset)
    tick |-> (state_q == ST_IDLE));
`endif

endmodule

// File: tb/tb_buzzer_mixer.sv
// -----------------------------------------------------------------------------
// tb_buzzer_mixer
//   Four mixer instances share one set of inputs, each with a different
//   configuration:
//     u0: SHIFT=0, CH_FS=7FFF, unsigned
//     u1: SHIFT=4, CH_FS=7FFF, unsigned
//     u2: SHIFT=0, CH_FS=FFFF, unsigned
//     u3: SHIFT=0, CH_FS=7FFF, signed output
//   Stimulus pushes one expected record per sample, computed by an integer
//   model. A monitor pops a record on every sample_valid and compares it.
// -----------------------------------------------------------------------------
module tb_buzzer_mixer;

  localparam int CH = 2;
  localparam int CE = 16;

  typedef struct packed {
    logic [3:0][15:0] audio;
    logic [3:0]       clip;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, enable, mute;
  logic [1:0]  buzzer;
  logic [7:0]  volume;
  logic [15:0] aout [4];
  logic        sv   [4];
  logic        clp  [4];

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q [$];
  int   lvl [4][CH];

  always #5 clk = ~clk;

  buzzer_mixer #(.CHANNELS(CH), .OUT_W(16), .VOL_W(4), .SHIFT(0), .CH_FS(16'h7FFF),
                 .CE_DIV(CE), .SIGNED_OUT(1'b0)) u0 (
    .clk_sys(clk), .reset(reset), .enable(enable), .mute(mute), .buzzer(buzzer),
    .volume(volume), .audio_out(aout[0]), .sample_valid(sv[0]), .clip(clp[0]));
  buzzer_mixer #(.CHANNELS(CH), .OUT_W(16), .VOL_W(4), .SHIFT(4), .CH_FS(16'h7FFF),
                 .CE_DIV(CE), .SIGNED_OUT(1'b0)) u1 (
    .clk_sys(clk), .reset(reset), .enable(enable), .mute(mute), .buzzer(buzzer),
    .volume(volume), .audio_out(aout[1]), .sample_valid(sv[1]), .clip(clp[1]));
  buzzer_mixer #(.CHANNELS(CH), .OUT_W(16), .VOL_W(4), .SHIFT(0), .CH_FS(16'hFFFF),
                 .CE_DIV(CE), .SIGNED_OUT(1'b0)) u2 (
    .clk_sys(clk), .reset(reset), .enable(enable), .mute(mute), .buzzer(buzzer),
    .volume(volume), .audio_out(aout[2]), .sample_valid(sv[2]), .clip(clp[2]));
  buzzer_mixer #(.CHANNELS(CH), .OUT_W(16), .VOL_W(4), .SHIFT(0), .CH_FS(16'h7FFF),
                 .CE_DIV(CE), .SIGNED_OUT(1'b1)) u3 (
    .clk_sys(clk), .reset(reset), .enable(enable), .mute(mute), .buzzer(buzzer),
    .volume(volume), .audio_out(aout[3]), .sample_valid(sv[3]), .clip(clp[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < CH; c++) lvl[k][c] = 0;
  endtask

  // One output sample per configuration, straight from the mixing rules:
  // the level moves by floor(diff / 2^SHIFT) (at least one unit), is scaled by
  // (vol+1)/16 unless vol is zero, and the channel sum saturates at 0xFFFF.
  task automatic model(input logic [1:0] bz, input logic [7:0] vol, input logic mu,
                       output exp_t e);
    for (int k = 0; k < 4; k++) begin
      int  sh  = (k == 1) ? 4 : 0;
      int  fs  = (k == 2) ? 65535 : 32767;
      int  sum = 0;
      int  res;
      bit  c;
      for (int ch = 0; ch < CH; ch++) begin
        int tgt = bz[ch] ? fs : 0;
        int d   = tgt - lvl[k][ch];
        int v   = int'(vol[ch*4 +: 4]);
        int s;
        if (d >= 0) s = d / (1 << sh);
        else        s = -((-d + (1 << sh) - 1) / (1 << sh));
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
        lvl[k][ch] += s;
        if (v != 0) sum += (lvl[k][ch] * (v + 1)) / 16;
      end
      c   = (sum > 65535);
      res = c ? 65535 : sum;
      if (mu) begin
        res = 0;
        c   = 1'b0;
      end
      if (k == 3) res = (res - 32768) & 65535;
      e.audio[k] = 16'(res);
      e.clip[k]  = c;
    end
  endtask

  // Entered on the negedge of an OUT cycle (or just after reset release).
  // lat > 0 checks the number of clocks until the next sample_valid.
  task automatic do_sample(input logic [1:0] bz, input logic [7:0] vol, input logic mu,
                           input bit pause, input bit glitch, input int lat);
    exp_t e;
    int   cnt = 0;
    buzzer = bz;
    volume = vol;
    mute   = mu;
    model(bz, vol, mu, e);
    exp_q.push_back(e);
    if (pause || glitch) begin
      // 14 or 15 clocks from an OUT cycle lands inside CALC.
      repeat ($urandom_range(15, 14)) @(posedge clk);
      @(negedge clk);
      if (glitch) begin
        buzzer = 2'($urandom);
        volume = 8'($urandom);
      end
      if (pause) begin
        enable = 1'b0;
        repeat ($urandom_range(5, 1)) @(negedge clk);
        enable = 1'b1;
      end
    end
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end while (!sv[0] && cnt < 200);
    if (cnt >= 200) check("sample_wait", {31'b0, sv[0]}, 32'd1);
    if (lat > 0) check("latency", cnt, lat);
  endtask

  // Monitor: every sample_valid consumes one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (sv[0] || sv[1] || sv[2] || sv[3])) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sample", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          check($sformatf("valid%0d", k), {31'b0, sv[k]}, 32'd1);
          check($sformatf("audio%0d", k), {16'b0, aout[k]}, {16'b0, e.audio[k]});
          check($sformatf("clip%0d", k), {31'b0, clp[k]}, {31'b0, e.clip[k]});
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    mute   = 1'b0;
    buzzer = 2'b00;
    volume = 8'hFF;
    model_reset();

    // Held in reset while the pins toggle: outputs stay silent.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      buzzer = 2'($urandom);
      #1;
      check("rst_audio0", {16'b0, aout[0]}, 32'h0);
      check("rst_audio3", {16'b0, aout[3]}, 32'h8000);
      check("rst_valid", {31'b0, sv[0] | sv[3]}, 32'd0);
      check("rst_clip", {31'b0, clp[0] | clp[2]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // First sample after release: tick at CE-1, valid CH+1 clocks later.
    do_sample(2'b01, 8'hFF, 1'b0, 1'b0, 1'b0, CE + CH);
    do_sample(2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, CE);
    check("both_high_u0", {16'b0, aout[0]}, 32'hFFFE);

    // Smoothed step up and back down on the SHIFT=4 instance.
    repeat (250) do_sample(2'b00, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    repeat (250) do_sample(2'b01, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    check("u1_settle_hi", {16'b0, aout[1]}, 32'h7FFF);
    repeat (250) do_sample(2'b00, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    check("u1_settle_lo", {16'b0, aout[1]}, 32'h0);

    // Saturation, mute, volume scaling and signed silence.
    do_sample(2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    check("sat_u2", {16'b0, aout[2]}, 32'hFFFF);
    do_sample(2'b11, 8'hFF, 1'b1, 1'b0, 1'b0, 0);
    check("mute_u2", {16'b0, aout[2]}, 32'h0);
    do_sample(2'b01, 8'hF7, 1'b0, 1'b0, 1'b0, 0);
    check("vol7_u0", {16'b0, aout[0]}, 32'h3FFF);
    do_sample(2'b01, 8'hF0, 1'b0, 1'b0, 1'b0, 0);
    check("vol0_u0", {16'b0, aout[0]}, 32'h0);
    do_sample(2'b00, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    check("signed_silence", {16'b0, aout[3]}, 32'h8000);

    // Random inputs with enable pauses and pin/volume changes inside CALC.
    repeat (150)
      do_sample(2'($urandom), 8'($urandom), ($urandom_range(7, 0) == 0),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0);

    // Reset pulse inside CALC: outputs clear at once and the next sample
    // only arrives after a full divider period.
    buzzer = 2'b11;
    volume = 8'hFF;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midcalc_rst_audio0", {16'b0, aout[0]}, 32'h0);
    check("midcalc_rst_audio3", {16'b0, aout[3]}, 32'h8000);
    check("midcalc_rst_valid", {31'b0, sv[0]}, 32'd0);
    check("midcalc_rst_clip", {31'b0, clp[2]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    do_sample(2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, CE + CH);
    repeat (20)
      do_sample(2'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, CE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
